// File: rtl/gtfraw_wrapper_pkg.sv
// Shared constants for the gtfraw wrapper toggle-handshake responder.
package gtfraw_wrapper_pkg;
  localparam int CNT_W_DEF = 4;
endpackage

// File: rtl/gtfraw_wrapper_toggle_responder_if.sv
// Toggle-request / event-stream bundle between initiator, responder and consumer.
// evt_valid/evt_ready: one event transfers on a clk edge where both are high;
// evt_valid never depends on evt_ready and holds until that transfer.
interface gtfraw_wrapper_toggle_responder_if
  import gtfraw_wrapper_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             req_toggle;
  logic             ack_toggle;
  logic             evt_valid;
  logic             evt_ready;
  logic [CNT_W-1:0] evt_pending;
  logic             proto_err;
  logic             proto_err_clr;

  modport slave (
    input  req_toggle, evt_ready, proto_err_clr,
    output ack_toggle, evt_valid, evt_pending, proto_err
  );

  modport master (
    output req_toggle, evt_ready, proto_err_clr,
    input  ack_toggle, evt_valid, evt_pending, proto_err
  );
endinterface

// File: rtl/gtfraw_wrapper_event_cnt.sv
// Saturating up/down counter of accepted, unconsumed events.
module gtfraw_wrapper_event_cnt
  import gtfraw_wrapper_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam logic [CNT_W-1:0] MAX_PEND = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    // Simultaneous inc and dec cancel; the guards keep the count from wrapping.
    if (inc && !dec && (count_q != MAX_PEND)) begin
      count_d = count_q + ONE;
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign full  = (count_q == MAX_PEND);
  assign empty = (count_q == '0);
endmodule

// File: rtl/gtfraw_wrapper_toggle_responder.sv
// Responds to level-toggle requests with a toggle acknowledge and queues each
// accepted request as an event for a valid/ready consumer.
module gtfraw_wrapper_toggle_responder
  import gtfraw_wrapper_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                                   clk,
  input  logic                                   reset,
  gtfraw_wrapper_toggle_responder_if.slave       bus
);
  logic ack_q, ack_d;
  logic req_d_q, req_d_d;
  logic err_q, err_d;
  logic outstanding, consume, accept, err_set;
  logic full, empty;

  always_comb begin
    outstanding = (bus.req_toggle != ack_q);
    consume     = !empty && bus.evt_ready;
    // A same-cycle consume frees the slot, so a full counter can still accept.
    accept      = outstanding && (!full || consume);
    ack_d       = ack_q ^ accept;
    req_d_d     = bus.req_toggle;
    err_set     = (bus.req_toggle != req_d_q) && (req_d_q != ack_q);
    err_d       = err_q;
    if (bus.proto_err_clr) err_d = 1'b0;
    if (err_set)           err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q   <= 1'b0;
      req_d_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      req_d_q <= req_d_d;
      err_q   <= err_d;
    end
  end

  gtfraw_wrapper_event_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (accept),
    .dec   (consume),
    .count (bus.evt_pending),
    .full  (full),
    .empty (empty)
  );

  assign bus.ack_toggle = ack_q;
  assign bus.evt_valid  = !empty;
  assign bus.proto_err  = err_q;
endmodule
